// File: rtl/riscv_pkg.sv
// Shared pipeline types: writeback source encodings and the memory-stage state enum.
// Pure declarations; no logic, no latency.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access; terminal flags TIMEOUT_CYCLES.
// Count updates one cycle after enable; clear has priority over enable.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_stage.sv
// Memory stage: word load/store over req/ready, registered writeback, comb forwarding path.
// 1-cycle latency (+N for N memory wait cycles); mem_stall freezes upstream while memory is busy.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_write_data,
  input  logic [XLEN-1:0] ex_pc_plus_4,
  input  logic [4:0]      ex_dr_num,
  input  logic [1:0]      ex_result_src,
  input  logic            ex_mem_write,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] fwd_data,
  output logic [4:0]      fwd_dr_num,
  output logic            fwd_reg_write,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_pc_plus_4,
  output logic [4:0]      wb_dr_num,
  output logic [1:0]      wb_result_src,
  output logic            wb_reg_write,
  output logic            mem_fault
);

  mem_state_t state_q, state_d;

  logic            access;
  logic            abort;
  logic            timer_clear;
  logic            timer_en;
  logic            timer_terminal;

  logic [XLEN-1:0] wb_alu_result_q, wb_alu_result_d;
  logic [XLEN-1:0] wb_read_data_q,  wb_read_data_d;
  logic [XLEN-1:0] wb_pc_plus_4_q,  wb_pc_plus_4_d;
  logic [4:0]      wb_dr_num_q,     wb_dr_num_d;
  logic [1:0]      wb_result_src_q, wb_result_src_d;
  logic            wb_reg_write_q,  wb_reg_write_d;
  logic            mem_fault_q,     mem_fault_d;

  assign access = ex_mem_read | ex_mem_write;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_terminal)
  );

  // Handshake FSM: the request stays up for the whole access because upstream holds ex_* while stalled.
  always_comb begin
    state_d     = state_q;
    dmem_req    = 1'b0;
    mem_stall   = 1'b0;
    abort       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            mem_stall = 1'b1;
            timer_en  = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          timer_clear = 1'b1;
          state_d     = IDLE;
        end else if (timer_terminal) begin
          abort       = 1'b1;
          timer_clear = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_stall = 1'b1;
          timer_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_we    = dmem_req & ex_mem_write;
  assign dmem_addr  = {ex_alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata = ex_write_data;

  assign fwd_data      = (ex_result_src == RESULT_SRC_PC4) ? ex_pc_plus_4 : ex_alu_result;
  assign fwd_dr_num    = ex_dr_num;
  assign fwd_reg_write = ex_reg_write;

  // A stalled cycle inserts a bubble; read data holds across non-memory ops.
  always_comb begin
    wb_alu_result_d = wb_alu_result_q;
    wb_read_data_d  = wb_read_data_q;
    wb_pc_plus_4_d  = wb_pc_plus_4_q;
    wb_dr_num_d     = wb_dr_num_q;
    wb_result_src_d = wb_result_src_q;
    wb_reg_write_d  = wb_reg_write_q;
    mem_fault_d     = mem_fault_q | abort;
    if (mem_stall) begin
      wb_reg_write_d = 1'b0;
    end else begin
      wb_alu_result_d = ex_alu_result;
      wb_pc_plus_4_d  = ex_pc_plus_4;
      wb_dr_num_d     = ex_dr_num;
      wb_result_src_d = ex_result_src;
      wb_reg_write_d  = ex_reg_write;
      if (access) begin
        wb_read_data_d = (ex_mem_write || abort) ? '0 : dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_pc_plus_4_q  <= '0;
      wb_dr_num_q     <= '0;
      wb_result_src_q <= '0;
      wb_reg_write_q  <= 1'b0;
      mem_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_pc_plus_4_q  <= wb_pc_plus_4_d;
      wb_dr_num_q     <= wb_dr_num_d;
      wb_result_src_q <= wb_result_src_d;
      wb_reg_write_q  <= wb_reg_write_d;
      mem_fault_q     <= mem_fault_d;
    end
  end

  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_pc_plus_4  = wb_pc_plus_4_q;
  assign wb_dr_num     = wb_dr_num_q;
  assign wb_result_src = wb_result_src_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign mem_fault     = mem_fault_q;

endmodule
